// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory port of the fetch sequencer: valid/ready request plus a
// single-cycle response strobe carrying the instruction word.
interface pc_fetch_unit_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer for the single-cycle RV32I core: one imem
// fetch per instruction, retire-time redirect and a sticky misalignment trap.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pc_fetch_unit_if.master        imem,
    input  logic                   next_pc_src_i,
    input  logic [31:0]            branch_target_i,
    input  logic                   stall_i,
    output logic                   inst_valid_o,
    output logic [31:0]            inst_o,
    output logic [31:0]            inst_pc_o,
    output logic [31:0]            pc_plus4_o,
    output logic                   misalign_trap_o,
    output logic [31:0]            instret_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_TRAP
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] instret_q;
    logic        req_valid_q;
    logic        inst_valid_q;
    logic        trap_q;

    logic [31:0] pc_inc;
    logic [31:0] pc_d;
    logic        redirect_bad;

    always_comb begin
        pc_inc       = pc_q + 32'd4;
        redirect_bad = next_pc_src_i & (branch_target_i[1:0] != 2'b00);
        pc_d         = next_pc_src_i ? branch_target_i : pc_inc;
    end

    // All outputs are updated on the edge that changes state, so each state
    // presents its own req_valid/inst_valid without decode after the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            instret_q    <= '0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            trap_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q     <= S_REQ;
                    req_valid_q <= 1'b1;
                end
                S_REQ: begin
                    if (imem.req_ready) begin
                        state_q     <= S_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem.rsp_valid) begin
                        state_q      <= S_HOLD;
                        inst_q       <= imem.rsp_data;
                        inst_valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        inst_valid_q <= 1'b0;
                        if (redirect_bad) begin
                            state_q <= S_TRAP;
                            trap_q  <= 1'b1;
                        end else begin
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                            pc_q        <= pc_d;
                            instret_q   <= instret_q + 32'd1;
                        end
                    end
                end
                S_TRAP: begin
                    req_valid_q  <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
                default: begin
                    state_q      <= S_TRAP;
                    req_valid_q  <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.req_valid  = req_valid_q;
    assign imem.req_addr   = pc_q;
    assign inst_valid_o    = inst_valid_q;
    assign inst_o          = inst_q;
    assign inst_pc_o       = pc_q;
    assign pc_plus4_o      = pc_inc;
    assign misalign_trap_o = trap_q;
    assign instret_o       = instret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a vector table for the fetch/branch/trap
// flow plus hand sequences for reset, backpressure, stall and PC wrap.
module tb_pc_fetch_unit;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        stall;
        logic        nps;
        logic [31:0] tgt;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ir;
        logic        e_trap;
    } vec_t;

    logic clk;
    logic rst_a_n;
    logic rst_b_n;

    pc_fetch_unit_if ifa ();
    pc_fetch_unit_if ifb ();

    logic        nps_a, stall_a;
    logic [31:0] tgt_a;
    logic        iv_a, trap_a;
    logic [31:0] inst_a, ipc_a, p4_a, ir_a;

    logic        nps_b, stall_b;
    logic [31:0] tgt_b;
    logic        iv_b, trap_b;
    logic [31:0] inst_b, ipc_b, p4_b, ir_b;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    vec_t vecs [13];

    pc_fetch_unit #(.RESET_PC(32'h0000_0100)) dut_a (
        .clk             (clk),
        .rst_n           (rst_a_n),
        .imem            (ifa),
        .next_pc_src_i   (nps_a),
        .branch_target_i (tgt_a),
        .stall_i         (stall_a),
        .inst_valid_o    (iv_a),
        .inst_o          (inst_a),
        .inst_pc_o       (ipc_a),
        .pc_plus4_o      (p4_a),
        .misalign_trap_o (trap_a),
        .instret_o       (ir_a)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk             (clk),
        .rst_n           (rst_b_n),
        .imem            (ifb),
        .next_pc_src_i   (nps_b),
        .branch_target_i (tgt_b),
        .stall_i         (stall_b),
        .inst_valid_o    (iv_b),
        .inst_o          (inst_b),
        .inst_pc_o       (ipc_b),
        .pc_plus4_o      (p4_b),
        .misalign_trap_o (trap_b),
        .instret_o       (ir_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic rqv, input logic [31:0] addr,
                         input logic iv, input logic [31:0] ins, input logic [31:0] ir,
                         input logic trap);
        chk({tag, ".req_valid"}, {31'b0, ifa.req_valid}, {31'b0, rqv});
        chk({tag, ".req_addr"},  ifa.req_addr, addr);
        chk({tag, ".inst_pc"},   ipc_a, addr);
        chk({tag, ".pc_plus4"},  p4_a, addr + 32'd4);
        chk({tag, ".inst_valid"}, {31'b0, iv_a}, {31'b0, iv});
        chk({tag, ".inst"},      inst_a, ins);
        chk({tag, ".instret"},   ir_a, ir);
        chk({tag, ".trap"},      {31'b0, trap_a}, {31'b0, trap});
    endtask

    task automatic set_a(input logic rdy, input logic rv, input logic [31:0] rdata,
                         input logic stall, input logic nps, input logic [31:0] tgt);
        ifa.req_ready = rdy;
        ifa.rsp_valid = rv;
        ifa.rsp_data  = rdata;
        stall_a       = stall;
        nps_a         = nps;
        tgt_a         = tgt;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdata,
                                input logic stall, input logic nps, input logic [31:0] tgt,
                                input logic e_rqv, input logic [31:0] e_addr, input logic e_iv,
                                input logic [31:0] e_inst, input logic [31:0] e_ir,
                                input logic e_trap);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.stall = stall; v.nps = nps; v.tgt = tgt;
        v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst;
        v.e_ir = e_ir; v.e_trap = e_trap;
        return v;
    endfunction

    initial begin
        // inputs applied before an edge, expectations checked 1ns after it
        vecs[0]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  1'b1, 32'h100, 1'b0, 32'h0,         32'd0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b1, 32'hEEEE_EEEE, 1'b0, 1'b0, 32'h0,  1'b0, 32'h100, 1'b0, 32'h0,         32'd0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 32'h0000_0A01, 1'b0, 1'b0, 32'h0,  1'b0, 32'h100, 1'b1, 32'h0000_0A01, 32'd0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  1'b1, 32'h104, 1'b0, 32'h0000_0A01, 32'd1, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h44, 1'b0, 32'h104, 1'b0, 32'h0000_0A01, 32'd1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 32'h0000_0A02, 1'b0, 1'b0, 32'h0,  1'b0, 32'h104, 1'b1, 32'h0000_0A02, 32'd1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  1'b1, 32'h108, 1'b0, 32'h0000_0A02, 32'd2, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  1'b0, 32'h108, 1'b0, 32'h0000_0A02, 32'd2, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, 32'h0000_0A03, 1'b0, 1'b0, 32'h0,  1'b0, 32'h108, 1'b1, 32'h0000_0A03, 32'd2, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h40, 1'b1, 32'h040, 1'b0, 32'h0000_0A03, 32'd3, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  1'b0, 32'h040, 1'b0, 32'h0000_0A03, 32'd3, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 32'h0000_0A04, 1'b0, 1'b0, 32'h0,  1'b0, 32'h040, 1'b1, 32'h0000_0A04, 32'd3, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h42, 1'b0, 32'h040, 1'b0, 32'h0000_0A04, 32'd3, 1'b1);

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        set_a(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        ifb.req_ready = 1'b1;
        ifb.rsp_valid = 1'b0;
        ifb.rsp_data  = 32'h0;
        nps_b = 1'b0; stall_b = 1'b0; tgt_b = 32'h0;

        repeat (2) step();
        chk_a("reset", 1'b0, 32'h100, 1'b0, 32'h0, 32'd0, 1'b0);
        rst_a_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            set_a(vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].stall, vecs[i].nps, vecs[i].tgt);
            step();
            chk_a($sformatf("vec%0d", i), vecs[i].e_rqv, vecs[i].e_addr, vecs[i].e_iv,
                  vecs[i].e_inst, vecs[i].e_ir, vecs[i].e_trap);
        end

        // Trap is sticky: no requests, instret frozen, stimulus ignored.
        set_a(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_a($sformatf("trap%0d", i), 1'b0, 32'h040, 1'b0, 32'h0000_0A04, 32'd3, 1'b1);
        end

        // Asynchronous reset clears trap mid-cycle.
        rst_a_n = 1'b0;
        #2;
        chk_a("trap_rst", 1'b0, 32'h100, 1'b0, 32'h0, 32'd0, 1'b0);
        set_a(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        rst_a_n = 1'b1;
        step();
        chk_a("bp_req", 1'b1, 32'h100, 1'b0, 32'h0, 32'd0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            step();
            chk_a($sformatf("bp_hold%0d", i), 1'b1, 32'h100, 1'b0, 32'h0, 32'd0, 1'b0);
        end
        set_a(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        chk_a("bp_acc", 1'b0, 32'h100, 1'b0, 32'h0, 32'd0, 1'b0);
        set_a(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a($sformatf("bp_wait%0d", i), 1'b0, 32'h100, 1'b0, 32'h0, 32'd0, 1'b0);
        end
        set_a(1'b0, 1'b1, 32'h0000_0B01, 1'b0, 1'b0, 32'h0);
        step();
        chk_a("bp_rsp", 1'b0, 32'h100, 1'b1, 32'h0000_0B01, 32'd0, 1'b0);

        // Stalled HOLD ignores a misaligned redirect and a stray response.
        set_a(1'b1, 1'b1, 32'h0000_DEAD, 1'b1, 1'b1, 32'h42);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_a($sformatf("stall%0d", i), 1'b0, 32'h100, 1'b1, 32'h0000_0B01, 32'd0, 1'b0);
        end
        set_a(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        chk_a("stall_ret", 1'b1, 32'h104, 1'b0, 32'h0000_0B01, 32'd1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk_a($sformatf("one_ret%0d", i), 1'b1, 32'h104, 1'b0, 32'h0000_0B01, 32'd1, 1'b0);
        end

        // Reset while in WAIT; a late response lands while in IDLE.
        set_a(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        chk_a("mid_wait", 1'b0, 32'h104, 1'b0, 32'h0000_0B01, 32'd1, 1'b0);
        rst_a_n = 1'b0;
        #2;
        chk_a("mid_rst", 1'b0, 32'h100, 1'b0, 32'h0, 32'd0, 1'b0);
        set_a(1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 1'b0, 32'h0);
        step();
        rst_a_n = 1'b1;
        step();
        chk_a("late_rsp", 1'b1, 32'h100, 1'b0, 32'h0, 32'd0, 1'b0);
        set_a(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        chk_a("refetch", 1'b0, 32'h100, 1'b0, 32'h0, 32'd0, 1'b0);
        set_a(1'b0, 1'b1, 32'h0000_0C01, 1'b0, 1'b0, 32'h0);
        step();
        chk_a("refetch_rsp", 1'b0, 32'h100, 1'b1, 32'h0000_0C01, 32'd0, 1'b0);

        // PC wrap on the second instance.
        rst_b_n = 1'b1;
        step();
        chk("wrap.req_valid", {31'b0, ifb.req_valid}, 32'd1);
        chk("wrap.addr0", ifb.req_addr, 32'hFFFF_FFFC);
        chk("wrap.pc_plus4", p4_b, 32'h0000_0000);
        step();
        ifb.rsp_valid = 1'b1;
        ifb.rsp_data  = 32'h0000_0D01;
        step();
        chk("wrap.inst_valid", {31'b0, iv_b}, 32'd1);
        chk("wrap.inst", inst_b, 32'h0000_0D01);
        ifb.rsp_valid = 1'b0;
        step();
        chk("wrap.req_valid1", {31'b0, ifb.req_valid}, 32'd1);
        chk("wrap.addr1", ifb.req_addr, 32'h0000_0000);
        chk("wrap.inst_pc", ipc_b, 32'h0000_0000);
        chk("wrap.instret", ir_b, 32'd1);
        chk("wrap.trap", {31'b0, trap_b}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
